instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1  request carries fields to encode.
REQ-004 SHALL have: in_ready  out  1  encoder can accept a request this cycle.
REQ-005 SHALL have: opcode  in  rv32i_opcode (7)  instruction format selector.
REQ-006 SHALL have: funct3  in  3;  funct7  in  7;  rs1, rs2, rd  in  5 each.
REQ-007 SHALL have: imm  in  32  full sign-extended immediate value (byte offset for B/J, full value for U).
REQ-008 SHALL have: out_valid  out  1;  out_ready  in  1;  out_word  out  32  encoded instruction.
REQ-009 SHALL have: out_err  out  1  qualifies out_word; 1 = request was unencodable.
REQ-010 SHALL have: word_cnt  out  16  accepted requests;  err_cnt  out  8  rejected requests.

Function
REQ-011 Accept SHALL occur on cycle where in_valid && in_ready; fields sampled only then.
REQ-012 in_ready SHALL equal (fifo occupancy < 2); no combinational path from out_ready.
REQ-013 Encoding SHALL be combinational at accept; result written into 2-entry output FIFO same edge; out_valid SHALL rise next cycle when FIFO was empty (latency 1).
REQ-014 Formats: R (op_reg): funct7|rs2|rs1|funct3|rd|op; I (op_imm, op_load, op_jalr, op_csr): imm[11:0]|rs1|funct3|rd|op; S (op_store): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op; B (op_br): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op; U (op_lui, op_auipc): imm[31:12]|rd|op; J (op_jal): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-015 Range legality: I/S imm[31:11] all equal; B imm[31:12] all equal and imm[0]=0; J imm[31:20] all equal and imm[0]=0; U imm[11:0]=0; R imm ignored.
REQ-016 Unlisted opcode or range violation SHALL store out_word=32'h00000013 (NOP) with out_err=1 and increment err_cnt.
REQ-017 Pop SHALL occur when out_valid && out_ready; FIFO strictly in order.
REQ-018 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, new word next at head after current pops.
REQ-019 At occupancy 2 push SHALL be impossible (in_ready=0); pop frees slot, in_ready=1 next cycle.
REQ-020 out_word/out_err SHALL hold stable while out_valid && !out_ready.
REQ-021 word_cnt SHALL increment on every accept (legal or not), saturating at 16'hFFFF; err_cnt saturates at 8'hFF.

Reset
REQ-022 rst low SHALL asynchronously clear FIFO occupancy and pointers, word_cnt, err_cnt.
REQ-023 During and after reset: out_valid=0, out_word=0, out_err=0, in_ready=1 from first cycle after rst deasserts.
REQ-024 Reset mid-transfer SHALL discard all buffered words; no pop occurs.

Structure
REQ-025 rv32i_opcode enum and NOP constant SHALL live in shared package rv32i_types.
REQ-026 FIFO SHALL be sub-module enc_fifo (width 33, depth 2); encode/range logic stays in instr_encoder.

Verification
REQ-027 ADDI rd=1 rs1=0 f3=0 imm=5 -> out_word=32'h00500093, out_err=0, one cycle after accept.
REQ-028 SW rs1=1 rs2=2 f3=2 imm=8 then LUI rd=5 imm=32'h12345000 back-to-back, out_ready=1 -> 32'h0020A423 then 32'h123452B7, word_cnt=2.
REQ-029 BEQ imm=3, then ADDI imm=2048 -> both out_word=32'h00000013, out_err=1, err_cnt=2.
REQ-030 out_ready=0, three requests offered -> two accepted, in_ready=0 on third; out_word held; release -> words in order.
REQ-031 rst low with two words buffered -> out_valid=0 immediately, counters 0, in_ready=1 after release.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I opcode enum, NOP word and immediate range helper
package rv32i_types;

    typedef enum logic [6:0] {
        op_load  = 7'h03,
        op_imm   = 7'h13,
        op_auipc = 7'h17,
        op_store = 7'h23,
        op_reg   = 7'h33,
        op_lui   = 7'h37,
        op_br    = 7'h63,
        op_jalr  = 7'h67,
        op_jal   = 7'h6F,
        op_csr   = 7'h73
    } rv32i_opcode;

    localparam logic [31:0] nop_insn = 32'h00000013;
    localparam int entry_width = 33;

    // True when v[31:msb] are all copies of one bit, i.e. v fits a signed field topped at msb
    function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = $signed(v) >>> msb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response handshake bundle for instr_encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;

    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, out_ready,
        output in_ready, out_valid, out_word, out_err
    );

    modport master (
        output in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, out_ready,
        input  in_ready, out_valid, out_word, out_err
    );
endinterface

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - two-entry in-order output FIFO; head reads zero when empty
module enc_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-to-word encoder with range checks and counters
module instr_encoder
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    instr_encoder_if.slave        bus,
    output logic [15:0]           word_cnt,
    output logic [7:0]            err_cnt
);
    logic [1:0]             occ;
    logic                   accept;
    logic                   pop;
    logic                   legal;
    logic [31:0]            word;
    logic [entry_width-1:0] entry;
    logic [entry_width-1:0] head;

    assign bus.in_ready  = (occ < 2'd2);
    assign bus.out_valid = (occ != 2'd0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        legal = 1'b1;
        word  = nop_insn;
        case (bus.opcode)
            op_reg: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            op_imm, op_load, op_jalr, op_csr: begin
                legal = sext_ok(bus.imm, 11);
                word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            op_store: begin
                legal = sext_ok(bus.imm, 11);
                word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            end
            op_br: begin
                legal = sext_ok(bus.imm, 12) && !bus.imm[0];
                word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                         bus.imm[4:1], bus.imm[11], bus.opcode};
            end
            op_lui, op_auipc: begin
                legal = (bus.imm[11:0] == 12'd0);
                word  = {bus.imm[31:12], bus.rd, bus.opcode};
            end
            op_jal: begin
                legal = sext_ok(bus.imm, 20) && !bus.imm[0];
                word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
            end
            default: legal = 1'b0;
        endcase
    end

    // Unencodable requests are replaced by a flagged NOP so the stream stays in order
    assign entry = legal ? {1'b0, word} : {1'b1, nop_insn};

    enc_fifo #(.WIDTH(entry_width)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .count     (occ)
    );

    assign bus.out_word = head[31:0];
    assign bus.out_err  = head[32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= 16'd0;
            err_cnt  <= 8'd0;
        end else if (accept) begin
            if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
            if (!legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
